// File: rtl/cdr_loop_filter.sv
// -----------------------------------------------------------------------------
// cdr_loop_filter
//
// Digital loop filter and phase selector for the bang-bang CDR. Up/down votes
// from the phase detector are integrated in a signed accumulator; when the
// accumulated vote reaches +/-THRESH the phase pointer steps (modulo NPHASE)
// and the accumulator restarts from zero. A lock indicator is raised after
// LOCK_CNT consecutive valid step-free samples and dropped on any step.
//
// Optional feature macro: CDR_LF_HOLDOFF_EN
//   defined   : votes are ignored for HOLDOFF cycles after every step
//   undefined : votes are used on every valid cycle, HOLDOFF is ignored
//
// Parameters:
//   NPHASE   number of selectable clock phases (>= 2)
//   THRESH   accumulator magnitude that triggers a phase step (>= 1)
//   LOCK_CNT consecutive valid step-free samples to assert locked (>= 1)
//   HOLDOFF  cycles votes are ignored after a step (holdoff build only)
//
// Ports:
//   clk        block clock, all state updates on posedge
//   rst        asynchronous active-low reset
//   pd_valid   qualifies up/down for this cycle
//   up         phase detector vote to advance
//   down       phase detector vote to retard
//   phase_sel  selected phase index
//   step_up    one-cycle pulse, phase_sel incremented this cycle
//   step_dn    one-cycle pulse, phase_sel decremented this cycle
//   locked     loop lock indicator
//
// Lock FSM:
//   state   | meaning
//   ACQUIRE | lock counter below LOCK_CNT, locked = 0
//   LOCKED  | LOCK_CNT step-free valid samples seen, locked = 1
// -----------------------------------------------------------------------------
module cdr_loop_filter #(
  parameter int NPHASE   = 8,
  parameter int THRESH   = 8,
  parameter int LOCK_CNT = 16,
  parameter int HOLDOFF  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pd_valid,
  input  logic                      up,
  input  logic                      down,
  output logic [$clog2(NPHASE)-1:0] phase_sel,
  output logic                      step_up,
  output logic                      step_dn,
  output logic                      locked
);

  localparam int PW = $clog2(NPHASE);
  localparam int AW = $clog2(THRESH) + 2;
  localparam int CW = $clog2(LOCK_CNT + 1);

  localparam logic [PW-1:0]        P_LAST = PW'(NPHASE - 1);
  localparam logic signed [AW-1:0] P_POS  = AW'(THRESH);
  localparam logic signed [AW-1:0] P_NEG  = -P_POS;
  localparam logic [CW-1:0]        P_LOCK = CW'(LOCK_CNT);

  // Elaboration-time sanity checks on the parameter set.
  if (NPHASE < 2) begin : g_chk_nphase
    $error("cdr_loop_filter: NPHASE must be at least 2");
  end
  if (THRESH < 1) begin : g_chk_thresh
    $error("cdr_loop_filter: THRESH must be at least 1");
  end
  if (LOCK_CNT < 1) begin : g_chk_lock
    $error("cdr_loop_filter: LOCK_CNT must be at least 1");
  end
  if (HOLDOFF < 0) begin : g_chk_holdoff
    $error("cdr_loop_filter: HOLDOFF must not be negative");
  end

  typedef enum logic {
    ACQUIRE = 1'b0,
    LOCKED  = 1'b1
  } lock_state_t;

  lock_state_t             r_state;
  logic signed [AW-1:0]    r_acc;
  logic        [PW-1:0]    r_phase;
  logic        [CW-1:0]    r_cnt;
  logic                    r_step_up;
  logic                    r_step_dn;
  logic                    r_locked;

  logic signed [AW-1:0]    w_vote;
  logic signed [AW-1:0]    w_acc_sum;
  logic                    w_step_up;
  logic                    w_step_dn;
  logic                    w_step;
  logic        [CW-1:0]    w_cnt_nx;
  logic                    w_hold_active;

`ifdef CDR_LF_HOLDOFF_EN
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [HW-1:0] P_HOLD = HW'(HOLDOFF);

  logic [HW-1:0] r_hold;

  assign w_hold_active = (r_hold != '0);

  // Holdoff counter runs on every clock, valid or not; a step reloads it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold <= '0;
    end else if (w_step) begin
      r_hold <= P_HOLD;
    end else if (r_hold != '0) begin
      r_hold <= r_hold - HW'(1);
    end
  end
`else
  assign w_hold_active = 1'b0;
`endif

  always_comb begin
    w_vote = '0;
    // During holdoff a valid vote still counts as a step-free sample for the
    // lock counter; it just contributes nothing to the accumulator.
    if (pd_valid && !w_hold_active) begin
      if (up && !down) begin
        w_vote = AW'(1);
      end else if (down && !up) begin
        w_vote = '1;
      end
    end
    w_acc_sum = r_acc + w_vote;
    w_step_up = pd_valid && (w_acc_sum == P_POS);
    w_step_dn = pd_valid && (w_acc_sum == P_NEG);
    w_step    = w_step_up || w_step_dn;

    w_cnt_nx = r_cnt;
    if (pd_valid) begin
      if (w_step) begin
        w_cnt_nx = '0;
      end else if (r_cnt != P_LOCK) begin
        w_cnt_nx = r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ACQUIRE;
      r_acc     <= '0;
      r_phase   <= '0;
      r_cnt     <= '0;
      r_step_up <= 1'b0;
      r_step_dn <= 1'b0;
      r_locked  <= 1'b0;
    end else begin
      r_step_up <= w_step_up;
      r_step_dn <= w_step_dn;
      r_cnt     <= w_cnt_nx;

      if (pd_valid) begin
        r_acc <= w_step ? '0 : w_acc_sum;
      end

      // Explicit wrap compare so non-power-of-two NPHASE never leaves range.
      if (w_step_up) begin
        r_phase <= (r_phase == P_LAST) ? '0 : r_phase + PW'(1);
      end else if (w_step_dn) begin
        r_phase <= (r_phase == '0) ? P_LAST : r_phase - PW'(1);
      end

      case (r_state)
        ACQUIRE: begin
          if (w_cnt_nx == P_LOCK) begin
            r_state  <= LOCKED;
            r_locked <= 1'b1;
          end
        end
        LOCKED: begin
          if (w_step) begin
            r_state  <= ACQUIRE;
            r_locked <= 1'b0;
          end
        end
        default: begin
          r_state  <= ACQUIRE;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign phase_sel = r_phase;
  assign step_up   = r_step_up;
  assign step_dn   = r_step_dn;
  assign locked    = r_locked;

endmodule

// File: tb/tb_cdr_loop_filter.sv
module tb_cdr_loop_filter;

  logic       clk;
  logic       rst;
  logic       pd_valid;
  logic       up;
  logic       down;

  logic [2:0] ph_a;
  logic       su_a, sd_a, lk_a;
  logic [2:0] ph_b;
  logic       su_b, sd_b, lk_b;

  int n_assert = 0;
  int n_fail   = 0;

  // Instance A: default parameters. Instance B: six phases, THRESH=1.
  cdr_loop_filter #(.NPHASE(8), .THRESH(8), .LOCK_CNT(16), .HOLDOFF(4)) dut_a (
    .clk(clk), .rst(rst), .pd_valid(pd_valid), .up(up), .down(down),
    .phase_sel(ph_a), .step_up(su_a), .step_dn(sd_a), .locked(lk_a)
  );

  cdr_loop_filter #(.NPHASE(6), .THRESH(1), .LOCK_CNT(3), .HOLDOFF(0)) dut_b (
    .clk(clk), .rst(rst), .pd_valid(pd_valid), .up(up), .down(down),
    .phase_sel(ph_b), .step_up(su_b), .step_dn(sd_b), .locked(lk_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CDR_LF_HOLDOFF_EN
  localparam bit HO_EN = 1'b1;
`else
  localparam bit HO_EN = 1'b0;
`endif

  // ---------------- behavioural model ----------------
  int m_acc [2];
  int m_ph  [2];
  int m_cnt [2];
  int m_hold[2];
  bit m_su  [2];
  bit m_sd  [2];
  bit m_lk  [2];

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0; m_ph[k] = 0; m_cnt[k] = 0; m_hold[k] = 0;
      m_su[k] = 0; m_sd[k] = 0; m_lk[k] = 0;
    end
  endtask

  task automatic m_step(input int k, input int np, input int th,
                        input int lc, input int ho);
    int v;
    v = 0;
    m_su[k] = 0;
    m_sd[k] = 0;
    if (pd_valid) begin
      if (up && !down) v = 1;
      else if (down && !up) v = -1;
      if (HO_EN && m_hold[k] != 0) v = 0;
      if (m_acc[k] + v == th) begin
        m_acc[k] = 0; m_ph[k] = (m_ph[k] + 1) % np; m_su[k] = 1;
      end else if (m_acc[k] + v == -th) begin
        m_acc[k] = 0; m_ph[k] = (m_ph[k] + np - 1) % np; m_sd[k] = 1;
      end else begin
        m_acc[k] = m_acc[k] + v;
      end
      if (m_su[k] || m_sd[k]) m_cnt[k] = 0;
      else if (m_cnt[k] < lc) m_cnt[k] = m_cnt[k] + 1;
    end
    if (HO_EN) begin
      if (m_su[k] || m_sd[k]) m_hold[k] = ho;
      else if (m_hold[k] > 0) m_hold[k] = m_hold[k] - 1;
    end
    m_lk[k] = (m_cnt[k] == lc);
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_reset();
    end else begin
      m_step(0, 8, 8, 16, 4);
      m_step(1, 6, 1, 3, 0);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("a.phase_sel", int'(ph_a), m_ph[0]);
    chk("a.step_up",   int'(su_a), int'(m_su[0]));
    chk("a.step_dn",   int'(sd_a), int'(m_sd[0]));
    chk("a.locked",    int'(lk_a), int'(m_lk[0]));
    chk("a.step_excl", int'(su_a & sd_a), 0);
    chk("b.phase_sel", int'(ph_b), m_ph[1]);
    chk("b.step_up",   int'(su_b), int'(m_su[1]));
    chk("b.step_dn",   int'(sd_b), int'(m_sd[1]));
    chk("b.locked",    int'(lk_b), int'(m_lk[1]));
    chk("b.phase_range", int'(ph_b < 3'd6), 1);
  end

  // ---------------- directed stimulus ----------------
  task automatic vote(input bit v, input bit u, input bit d);
    pd_valid = v; up = u; down = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) vote(1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".a_out"}, int'({ph_a, su_a, sd_a, lk_a}), 0);
    chk({name, ".b_out"}, int'({ph_b, su_b, sd_b, lk_b}), 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; pd_valid = 1'b0; up = 1'b0; down = 1'b0;
    #3;
    chk_all_zero("reset_state");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Seven votes, then reset: the partial accumulation must be discarded.
    repeat (7) vote(1'b1, 1'b1, 1'b0);
    chk("pre_reset.step_up", int'(su_a), 0);
    chk("pre_reset.phase",   int'(ph_a), 0);
    pulse_reset();

    // Eight fresh votes needed; B (THRESH=1) walks 1,2,3,4,5,0,1,2.
    for (int i = 0; i < 8; i++) begin
      vote(1'b1, 1'b1, 1'b0);
      chk("b.wrap6_seq", int'(ph_b), (i + 1) % 6);
      if (i < 7) chk("a.no_early_step", int'(su_a), 0);
    end
    chk("a.first_step_up", int'(su_a), 1);
    chk("a.first_phase",   int'(ph_a), 1);

    // Reset asserted while step_up is high and phase is non-zero.
    #2;
    pulse_reset();

    // Eight groups of eight up votes walk phase 1..7 and wrap to 0.
    for (int g = 0; g < 8; g++) begin
      repeat (8) vote(1'b1, 1'b1, 1'b0);
      chk("a.group_step_up", int'(su_a), 1);
      chk("a.group_phase",   int'(ph_a), (g + 1) % 8);
      idle(5);
    end

    // Eight downs from phase 0 wrap to 7.
    repeat (8) vote(1'b1, 1'b0, 1'b1);
    chk("a.step_dn",      int'(sd_a), 1);
    chk("a.dn_wrap_phase", int'(ph_a), 7);
    idle(5);

    // Mixed: net +2, ties and invalid cycles contribute nothing.
    repeat (5) vote(1'b1, 1'b1, 1'b0);
    repeat (3) vote(1'b1, 1'b0, 1'b1);
    repeat (2) vote(1'b1, 1'b1, 1'b1);
    repeat (3) vote(1'b0, 1'b1, 1'b0);
    repeat (5) vote(1'b1, 1'b1, 1'b0);
    chk("a.mixed_no_step", int'(su_a | sd_a), 0);
    chk("a.mixed_phase",   int'(ph_a), 7);
    vote(1'b1, 1'b1, 1'b0);
    chk("a.mixed_step_up", int'(su_a), 1);
    chk("a.mixed_phase_wrap", int'(ph_a), 0);
    idle(5);

    // Lock: sixteen alternating samples, locked exactly after the 16th.
    for (int i = 0; i < 16; i++) begin
      vote(1'b1, (i % 2) == 0, (i % 2) == 1);
      chk("a.lock_seq", int'(lk_a), (i == 15) ? 1 : 0);
    end

    // Loss of lock coincides with the step pulse.
    repeat (7) vote(1'b1, 1'b1, 1'b0);
    chk("a.still_locked", int'(lk_a), 1);
    vote(1'b1, 1'b1, 1'b0);
    chk("a.loss_step_up", int'(su_a), 1);
    chk("a.loss_unlocked", int'(lk_a), 0);

    // Votes right after a step: holdoff swallows the first four.
    for (int i = 1; i <= 12; i++) begin
      vote(1'b1, 1'b1, 1'b0);
      if (i == 8)  chk("a.post_step8",  int'(su_a), HO_EN ? 0 : 1);
      if (i == 12) chk("a.post_step12", int'(su_a), HO_EN ? 1 : 0);
    end
    chk("a.post_phase", int'(ph_a), 2);

    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
